// File: rtl/bin2bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
// Optional leading-zero blanking is enabled by defining BIN2BCD_BLANK_EN.
package bin2bcd_pkg;

  // FSM encoding kept as plain constants for compatibility with older tools.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADJ_THRESH  = 4'd5;
  localparam logic [3:0] ADJ_ADD     = 4'd3;

endpackage

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// Single-digit double-dabble correction: add 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adj
);

  // Pure combinational add-3-if-at-least-5.
  always_comb begin
    adj = digit;
    if (digit >= ADJ_THRESH) adj = digit + ADJ_ADD;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// Define BIN2BCD_BLANK_EN to add the registered blank_mask output that flags
// leading-zero digits for the display mux.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for in_valid; in_ready high
//   ST_SHIFT | adjusting and shifting one binary bit per cycle, BIN_W cycles
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 17,
  parameter int DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BIN_W-1:0]              in_bin,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DIGITS*BCD_DIGIT_W-1:0] out_bcd,
  output logic                          out_valid,
  output logic                          out_ovf
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]             blank_mask
`endif
);

  localparam int BCD_W = DIGITS * BCD_DIGIT_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic             ovf_sticky;

  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_shift;
  logic             shift_out;
  logic             last_iter;

  // Per-digit correction ahead of the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (bcd_sr[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adj   (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Next scratch value after one iteration; the bit leaving the top digit
  // means the value no longer fits in DIGITS digits.
  always_comb begin
    bcd_shift = {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
    shift_out = bcd_adj[BCD_W-1];
    last_iter = (state == ST_SHIFT) && (cnt == CNT_LAST);
  end

  assign in_ready = (state == ST_IDLE);

  // FSM, iteration counter, shift registers and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bin_sr     <= '0;
      bcd_sr     <= '0;
      ovf_sticky <= 1'b0;
      out_bcd    <= '0;
      out_ovf    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == ST_IDLE) begin
        if (in_valid) begin
          bin_sr     <= in_bin;
          bcd_sr     <= '0;
          ovf_sticky <= 1'b0;
          cnt        <= '0;
          state      <= ST_SHIFT;
        end
      end else begin
        bcd_sr     <= bcd_shift;
        bin_sr     <= {bin_sr[BIN_W-2:0], 1'b0};
        ovf_sticky <= ovf_sticky | shift_out;
        cnt        <= cnt + 1'b1;
        if (last_iter) begin
          out_bcd   <= bcd_shift;
          out_ovf   <= ovf_sticky | shift_out;
          out_valid <= 1'b1;
          cnt       <= '0;
          state     <= ST_IDLE;
        end
      end
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_next;
  logic              upper_zero;

  // A digit is blanked when it and every digit above it are zero; the
  // units digit always stays lit so a zero result still shows "0".
  always_comb begin
    blank_next = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero    = upper_zero & (bcd_shift[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      blank_next[i] = upper_zero & (i != 0);
    end
  end

  // Blank mask is captured together with out_bcd and held between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_mask <= '0;
    end else if (last_iter) begin
      blank_mask <= blank_next;
    end
  end
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed testbench for bin2bcd_seq (BIN_W=17, DIGITS=5).
// Blank-mask checks are compiled in when BIN2BCD_BLANK_EN is defined.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic [16:0] in_bin;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] out_bcd;
  logic        out_valid;
  logic        out_ovf;
`ifdef BIN2BCD_BLANK_EN
  logic [4:0]  blank_mask;
`endif

  int n_vec;
  int n_err;

  logic [19:0] got_bcd;
  logic        got_ovf;
  int          got_lat;
  logic [4:0]  got_mask;

  bin2bcd_seq #(.BIN_W(17), .DIGITS(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_bin     (in_bin),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_bcd    (out_bcd),
    .out_valid  (out_valid),
    .out_ovf    (out_ovf)
`ifdef BIN2BCD_BLANK_EN
    ,
    .blank_mask (blank_mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept one value (caller guarantees idle), then wait for the strobe.
  task automatic run_conv(input logic [16:0] val);
    in_bin   = val;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_bin   = 17'h1ABCD;
    got_lat  = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        got_lat = c;
        break;
      end
    end
    got_bcd = out_bcd;
    got_ovf = out_ovf;
`ifdef BIN2BCD_BLANK_EN
    got_mask = blank_mask;
`else
    got_mask = 5'b0;
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_bin = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_vec++; if (out_bcd !== 20'h0) begin n_err++; $display("FAIL reset_bcd got %h want 00000", out_bcd); end
    n_vec++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", out_ovf); end
`ifdef BIN2BCD_BLANK_EN
    n_vec++; if (blank_mask !== 5'b0) begin n_err++; $display("FAIL reset_mask got %b want 00000", blank_mask); end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_values;
    logic [16:0] vin  [5];
    logic [19:0] vbcd [5];
    logic        vovf [5];
    logic [4:0]  vmask[5];
    vin[0] = 17'd0;      vbcd[0] = 20'h00000; vovf[0] = 1'b0; vmask[0] = 5'b11110;
    vin[1] = 17'd99999;  vbcd[1] = 20'h99999; vovf[1] = 1'b0; vmask[1] = 5'b00000;
    vin[2] = 17'd42;     vbcd[2] = 20'h00042; vovf[2] = 1'b0; vmask[2] = 5'b11100;
    vin[3] = 17'd131071; vbcd[3] = 20'h31071; vovf[3] = 1'b1; vmask[3] = 5'b00000;
    vin[4] = 17'd100000; vbcd[4] = 20'h00000; vovf[4] = 1'b1; vmask[4] = 5'b11110;
    for (int i = 0; i < 5; i++) begin
      run_conv(vin[i]);
      n_vec++; if (got_lat !== 17) begin n_err++; $display("FAIL latency[%0d] got %0d want 17", i, got_lat); end
      n_vec++; if (got_bcd !== vbcd[i]) begin n_err++; $display("FAIL bcd[%0d] got %h want %h", i, got_bcd, vbcd[i]); end
      n_vec++; if (got_ovf !== vovf[i]) begin n_err++; $display("FAIL ovf[%0d] got %b want %b", i, got_ovf, vovf[i]); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ready_at_done[%0d] got %b want 1", i, in_ready); end
`ifdef BIN2BCD_BLANK_EN
      n_vec++; if (got_mask !== vmask[i]) begin n_err++; $display("FAIL mask[%0d] got %b want %b", i, got_mask, vmask[i]); end
`endif
      @(posedge clk); #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL strobe_width[%0d] got %b want 0", i, out_valid); end
      n_vec++; if (out_bcd !== vbcd[i]) begin n_err++; $display("FAIL bcd_hold[%0d] got %h want %h", i, out_bcd, vbcd[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int t1;
    int t2;
    in_bin = 17'd12345; in_valid = 1'b1;
    @(posedge clk); #1;
    in_bin = 17'd54321;
    t1 = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin t1 = c; break; end
    end
    n_vec++; if (t1 !== 17) begin n_err++; $display("FAIL b2b_lat1 got %0d want 17", t1); end
    n_vec++; if (out_bcd !== 20'h12345) begin n_err++; $display("FAIL b2b_bcd1 got %h want 12345", out_bcd); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_bin = 17'h0;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_busy got %b want 0", in_ready); end
    t2 = -1;
    for (int c = 2; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin t2 = c; break; end
    end
    n_vec++; if (t2 !== 18) begin n_err++; $display("FAIL b2b_spacing got %0d want 18", t2); end
    n_vec++; if (out_bcd !== 20'h54321) begin n_err++; $display("FAIL b2b_bcd2 got %h want 54321", out_bcd); end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_ignore;
    int pulses;
    int first;
    in_bin = 17'd1234; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_bin = '0;
    pulses = 0; first = -1;
    for (int c = 1; c <= 50; c++) begin
      if (c == 5) begin in_valid = 1'b1; in_bin = 17'd777; end
      if (c == 6) begin in_valid = 1'b0; in_bin = '0; end
      @(posedge clk); #1;
      if (out_valid) begin
        pulses++;
        if (first < 0) begin
          first = c;
          got_bcd = out_bcd;
        end
      end
    end
    n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL busy_pulses got %0d want 1", pulses); end
    n_vec++; if (first !== 17) begin n_err++; $display("FAIL busy_lat got %0d want 17", first); end
    n_vec++; if (got_bcd !== 20'h01234) begin n_err++; $display("FAIL busy_bcd got %h want 01234", got_bcd); end
  endtask

  task automatic test_reset_abort;
    int pulses;
    in_bin = 17'd65535; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_bin = '0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid got %b want 0", out_valid); end
    n_vec++; if (out_bcd !== 20'h0) begin n_err++; $display("FAIL abort_bcd got %h want 00000", out_bcd); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready got %b want 1", in_ready); end
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL abort_pulses got %0d want 0", pulses); end
    run_conv(17'd65535);
    n_vec++; if (got_lat !== 17) begin n_err++; $display("FAIL after_abort_lat got %0d want 17", got_lat); end
    n_vec++; if (got_bcd !== 20'h65535) begin n_err++; $display("FAIL after_abort_bcd got %h want 65535", got_bcd); end
    n_vec++; if (got_ovf !== 1'b0) begin n_err++; $display("FAIL after_abort_ovf got %b want 0", got_ovf); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    got_mask = '0;
    test_reset();
    test_values();
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
